// File: rtl/clk_switch_ctrl_if.sv
// Request/status bundle between the switch requester and clk_switch_ctrl.
`timescale 1ns/1ps
interface clk_switch_ctrl_if;
  logic req_valid;
  logic req_sel;
  logic req_ready;
  logic selection;
  logic busy;
  logic done;
  logic err;

  modport master (
    output req_valid, req_sel,
    input  req_ready, selection, busy, done, err
  );

  modport slave (
    input  req_valid, req_sel,
    output req_ready, selection, busy, done, err
  );
endinterface

// File: rtl/clk_switch_ctrl.sv
// Clock-switch controller: verifies the target clock is alive via its
// heartbeat, drives the glitch-free mux select, then settles and dwells.
`timescale 1ns/1ps
module clk_switch_ctrl #(
  parameter int unsigned CHECK_WINDOW  = 64,
  parameter int unsigned MIN_EDGES     = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned DWELL_CYCLES  = 1000
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic            hb1_in,
  input  logic            hb2_in,
  clk_switch_ctrl_if.slave sw
);

  localparam int unsigned WIN_W    = $clog2(CHECK_WINDOW + 1);
  localparam int unsigned EDGE_W   = $clog2(MIN_EDGES + 1);
  localparam int unsigned HOLD_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SWITCH = 3'd2,
    SETTLE = 3'd3,
    DWELL  = 3'd4
  } state_t;

  state_t              state, state_d;
  logic [WIN_W-1:0]    win_cnt, win_d;
  logic [EDGE_W-1:0]   edge_cnt, edge_d;
  logic [HOLD_W-1:0]   hold_cnt, hold_d;
  logic                target, target_d;
  logic                sel_q, sel_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [2:0]          hb1_sync, hb2_sync;
  logic                hb1_edge, hb2_edge, tgt_edge;

  assign hb1_edge = hb1_sync[1] ^ hb1_sync[2];
  assign hb2_edge = hb2_sync[1] ^ hb2_sync[2];
  assign tgt_edge = target ? hb2_edge : hb1_edge;

  // State, counters, heartbeat synchronisers and registered outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= IDLE;
      win_cnt  <= '0;
      edge_cnt <= '0;
      hold_cnt <= '0;
      target   <= 1'b0;
      sel_q    <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      hb1_sync <= '0;
      hb2_sync <= '0;
    end else begin
      state    <= state_d;
      win_cnt  <= win_d;
      edge_cnt <= edge_d;
      hold_cnt <= hold_d;
      target   <= target_d;
      sel_q    <= sel_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      hb1_sync <= {hb1_sync[1:0], hb1_in};
      hb2_sync <= {hb2_sync[1:0], hb2_in};
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    win_d    = win_cnt;
    edge_d   = edge_cnt;
    hold_d   = hold_cnt;
    target_d = target;
    sel_d    = sel_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state)
      IDLE: begin
        if (sw.req_valid && ready_q) begin
          target_d = sw.req_sel;
          if (sw.req_sel == sel_q) begin
            done_d = 1'b1;
          end else begin
            state_d = CHECK;
            win_d   = '0;
            edge_d  = '0;
          end
        end
      end
      CHECK: begin
        if (tgt_edge && (edge_cnt != EDGE_W'(MIN_EDGES))) begin
          edge_d = edge_cnt + EDGE_W'(1);
        end
        if (win_cnt == WIN_W'(CHECK_WINDOW - 1)) begin
          if (edge_cnt >= EDGE_W'(MIN_EDGES)) begin
            state_d = SWITCH;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else begin
          win_d = win_cnt + WIN_W'(1);
        end
      end
      SWITCH: begin
        sel_d   = target;
        hold_d  = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (hold_cnt == HOLD_W'(SETTLE_CYCLES - 1)) begin
          done_d  = 1'b1;
          hold_d  = '0;
          state_d = DWELL;
        end else begin
          hold_d = hold_cnt + HOLD_W'(1);
        end
      end
      DWELL: begin
        if (hold_cnt == HOLD_W'(DWELL_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  assign sw.selection = sel_q;
  assign sw.req_ready = ready_q;
  assign sw.busy      = busy_q;
  assign sw.done      = done_q;
  assign sw.err       = err_q;

endmodule

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
- Control stage directly upstream of the glitch-free clock mux (user_bufgmux_ctrl).
- Accepts switch requests, checks that the target clock is actually toggling, and only then drives the mux `selection` line.
- After a switch it holds for a settle period and then a minimum dwell period before taking another request.
- Runs on a free-running, always-present control clock `aclk`. Source-clock liveness arrives as heartbeat toggles from each mux input domain.

Parameters:
CHECK_WINDOW, 64, aclk cycles spent counting target heartbeat edges (>=1)
MIN_EDGES, 4, heartbeat edges required in window to declare target alive (1..CHECK_WINDOW)
SETTLE_CYCLES, 16, aclk cycles after selection change before done (>=1)
DWELL_CYCLES, 1000, aclk cycles after done before next request is accepted (>=1)

Ports:
aclk  input  1  control clock; all logic on rising edge
areset  input  1  reset, synchronous, active-high
req_valid  input  1  switch request valid
req_sel  input  1  requested mux input (0 = aclk_in1, 1 = aclk_in2)
req_ready  output  1  request accepted when req_valid && req_ready
hb1_in  input  1  divide-by-2 toggle from aclk_in1 domain (asynchronous)
hb2_in  input  1  divide-by-2 toggle from aclk_in2 domain (asynchronous)
selection  output  1  registered select to the clock mux
busy  output  1  high whenever FSM is not IDLE
done  output  1  one-cycle pulse: request completed
err  output  1  one-cycle pulse: target clock dead, request rejected

Behaviour:
- Reset (synchronous, active-high): while areset=1 after an edge, all of the following hold:
  - FSM = IDLE
  - selection=0, req_ready=0, busy=0, done=0, err=0
  - all counters cleared; heartbeat synchronisers cleared
- First cycle after areset deasserts: req_ready=1.
- Reset mid-operation aborts any state and forces selection=0 on the next edge. This is legal because the mux is glitch-free.
- Heartbeats:
  - Each hbN_in passes through a 2-flop synchroniser, then a third flop.
  - Edge = the synchronised value differs from the third flop.
  - Edges are counted only for the target input during CHECK.
  - The edge counter saturates at MIN_EDGES.
  - aclk frequency must exceed 2x each heartbeat toggle rate.
- req_ready = 1 only in IDLE and not in reset. busy = (state != IDLE).
- FSM states:
  - IDLE: on accept, latch target = req_sel.
    - If target == selection: next state IDLE, done=1 on the next cycle, req_ready stays 1 (no check, no dwell).
    - Otherwise: go to CHECK; clear the window counter and edge counter.
  - CHECK: lasts exactly CHECK_WINDOW cycles; no early exit.
    - On the last cycle, if edge count >= MIN_EDGES: go to SWITCH.
    - Otherwise: err=1 next cycle, return to IDLE, selection unchanged.
  - SWITCH: one cycle; selection <= target.
  - SETTLE: exactly SETTLE_CYCLES cycles. done=1 on the cycle after the last SETTLE cycle, coincident with entering DWELL.
  - DWELL: exactly DWELL_CYCLES cycles (req_ready=0), then IDLE.
- Latency, with the accept edge as cycle 0:
  - selection changes at cycle CHECK_WINDOW+2.
  - done pulses at cycle CHECK_WINDOW+SETTLE_CYCLES+2.
  - req_ready returns at cycle CHECK_WINDOW+SETTLE_CYCLES+DWELL_CYCLES+2.
  - err (on failure) pulses at cycle CHECK_WINDOW+1; req_ready returns the same cycle.
- done and err are never high together. Each is exactly one cycle wide.
- req_valid while req_ready=0 is ignored. There is no queuing; the requester must hold req_valid.
- req_sel changes after accept have no effect until the next accept.
- Counters are sized $clog2(param+1) and never wrap during normal operation.

Test Plan:
- Reset with selection high (prior switch): assert areset 1 cycle -> selection=0, busy=0, req_ready=1 the cycle after release.
- Both clocks running (aclk 200 MHz, hb1 25 MHz, hb2 37.5 MHz); request req_sel=1 -> selection rises at cycle 66, done pulse at cycle 82, req_ready back at cycle 1082, no err.
- hb2_in held constant; request req_sel=1 -> err pulse at cycle 65, selection stays 0, no done, req_ready=1 at cycle 65.
- Request req_sel=0 while selection=0 -> done at cycle 1, busy never asserts, req_ready stays 1.
- Hold req_valid=1 with alternating req_sel through DWELL -> no accept until req_ready returns; exactly one switch per completed dwell; selection never changes during CHECK, SETTLE or DWELL.
- Assert areset during SETTLE after selection went to 1 -> selection=0 and state IDLE after reset; no done pulse; a new request then completes normally.
